// File: rtl/module_fifo_flagged.sv
// module_fifo_flagged: single-clock first-word-fall-through FIFO with arbitrary
// depth, occupancy count, programmable almost flags, synchronous flush and
// sticky overflow/underflow error bits.
//
// Handshake: a write is accepted (wr_ok) when we is high and the FIFO is not
// full, or when a read is accepted in the same cycle. A read is accepted (rd_ok)
// when re is high and the FIFO is not empty. Requests that are not accepted
// leave the contents untouched and set the matching sticky error flag.
module module_fifo_flagged #(
    parameter int XLEN      = 32,
    parameter int LENGTH    = 4,
    parameter int AF_THRESH = LENGTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic                          re,
    input  logic                          flush,
    input  logic [XLEN-1:0]               din,
    output logic [XLEN-1:0]               dout,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(LENGTH+1)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam int PW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(LENGTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    logic [XLEN-1:0] mem [LENGTH];
    logic [PW-1:0]   front_ptr;
    logic [PW-1:0]   back_ptr;
    logic [PW-1:0]   front_next;
    logic [PW-1:0]   back_next;
    logic            wr_ok;
    logic            rd_ok;

    // Status flags decode straight from the registered count.
    assign empty        = (count == '0);
    assign full         = (count == CNT_FULL);
    assign almost_empty = (count <= CNT_AE);
    assign almost_full  = (count >= CNT_AF);

    // Head word falls through with no latency; forced to zero while empty.
    assign dout = empty ? '0 : mem[front_ptr];

    // Accept decisions and pointer increments; wrap is an explicit compare so
    // non-power-of-two depths work.
    always_comb begin
        wr_ok      = we & (~full | re);
        rd_ok      = re & ~empty;
        front_next = (front_ptr == PTR_LAST) ? '0 : front_ptr + PW'(1);
        back_next  = (back_ptr == PTR_LAST) ? '0 : back_ptr + PW'(1);
    end

    // Storage write; contents are never reset or flushed, only pointers are.
    always_ff @(posedge clk) begin
        if (reset && !flush && wr_ok) begin
            mem[back_ptr] <= din;
        end
    end

    // Pointers, occupancy and sticky flags: reset, then flush, then normal operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            front_ptr <= '0;
            back_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            front_ptr <= '0;
            back_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                back_ptr <= back_next;
            end
            if (rd_ok) begin
                front_ptr <= front_next;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (we && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (re && !rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_fifo_flagged.sv
// tb_module_fifo_flagged: directed bench for the flagged FIFO. Instance a uses
// the default depth of 4; instance b uses depth 5 with almost_empty at <= 2 to
// exercise non-power-of-two pointer wrap.
module tb_module_fifo_flagged;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance a: LENGTH 4 ----------------
    logic        we_a, re_a, flush_a;
    logic [31:0] din_a, dout_a;
    logic        empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
    logic [2:0]  count_a;

    module_fifo_flagged #(.XLEN(32), .LENGTH(4)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .we           (we_a),
        .re           (re_a),
        .flush        (flush_a),
        .din          (din_a),
        .dout         (dout_a),
        .empty        (empty_a),
        .full         (full_a),
        .almost_empty (ae_a),
        .almost_full  (af_a),
        .count        (count_a),
        .overflow     (ovf_a),
        .underflow    (unf_a)
    );

    // ---------------- instance b: LENGTH 5, AE_THRESH 2 ----------------
    logic        we_b, re_b, flush_b;
    logic [31:0] din_b, dout_b;
    logic        empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
    logic [2:0]  count_b;

    module_fifo_flagged #(.XLEN(32), .LENGTH(5), .AE_THRESH(2)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .we           (we_b),
        .re           (re_b),
        .flush        (flush_b),
        .din          (din_b),
        .dout         (dout_b),
        .empty        (empty_b),
        .full         (full_b),
        .almost_empty (ae_b),
        .almost_full  (af_b),
        .count        (count_b),
        .overflow     (ovf_b),
        .underflow    (unf_b)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt;
    logic [31:0] exp_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic cyc_a(input logic w, input logic r, input logic [31:0] d);
        we_a = w; re_a = r; din_a = d;
        @(posedge clk); #1;
        we_a = 1'b0; re_a = 1'b0; din_a = '0;
    endtask

    task automatic flush_cyc_a(input logic w, input logic [31:0] d);
        flush_a = 1'b1; we_a = w; din_a = d;
        @(posedge clk); #1;
        flush_a = 1'b0; we_a = 1'b0; din_a = '0;
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic [31:0] d);
        we_b = w; re_b = r; din_b = d;
        @(posedge clk); #1;
        we_b = 1'b0; re_b = 1'b0; din_b = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        we_a = 0; re_a = 0; flush_a = 0; din_a = '0;
        we_b = 0; re_b = 0; flush_b = 0; din_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset values
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_empty", 64'(empty_a), 64'd1);
        chk("rst_full",  64'(full_a),  64'd0);
        chk("rst_ae",    64'(ae_a),    64'd1);
        chk("rst_af",    64'(af_a),    64'd0);
        chk("rst_ovf",   64'(ovf_a),   64'd0);
        chk("rst_unf",   64'(unf_a),   64'd0);
        chk("rst_dout",  64'(dout_a),  64'd0);

        // Read from empty: refused, underflow sticks
        cyc_a(1'b0, 1'b1, 32'h0);
        chk("unf_empty", 64'(empty_a), 64'd1);
        chk("unf_count", 64'(count_a), 64'd0);
        chk("unf_flag",  64'(unf_a),   64'd1);
        cyc_a(1'b0, 1'b0, 32'h0);
        chk("unf_sticky", 64'(unf_a), 64'd1);

        // Flush clears the sticky flag
        flush_cyc_a(1'b0, 32'h0);
        chk("flush_unf", 64'(unf_a), 64'd0);

        // Fill to full
        exp_q = {32'hdeadbeef, 32'hbababebe, 32'hcacacaca, 32'hfeedbeef};
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1, 1'b0, exp_q[i]);
            chk("fill_count", 64'(count_a), 64'(i + 1));
            chk("fill_af",    64'(af_a),    64'((i + 1) >= 3));
            chk("fill_full",  64'(full_a),  64'((i + 1) == 4));
            chk("fill_ae",    64'(ae_a),    64'((i + 1) <= 1));
            chk("fill_dout",  64'(dout_a),  64'h0000_0000_dead_beef);
        end

        // Write into full: refused, overflow sticks, contents unchanged
        cyc_a(1'b1, 1'b0, 32'h0);
        chk("ovf_count", 64'(count_a), 64'd4);
        chk("ovf_flag",  64'(ovf_a),   64'd1);
        chk("ovf_dout",  64'(dout_a),  64'h0000_0000_dead_beef);

        // Simultaneous write and read while full
        chk("wr_rd_full_pre", 64'(dout_a), 64'h0000_0000_dead_beef);
        cyc_a(1'b1, 1'b1, 32'h01010101);
        void'(exp_q.pop_front());
        exp_q.push_back(32'h01010101);
        chk("wr_rd_full_dout",  64'(dout_a),  64'h0000_0000_baba_bebe);
        chk("wr_rd_full_count", 64'(count_a), 64'd4);
        chk("wr_rd_full_full",  64'(full_a),  64'd1);
        chk("wr_rd_full_ovf",   64'(ovf_a),   64'd1);

        // Drain: bababebe, cacacaca, feedbeef, 01010101
        for (int i = 0; i < 4; i++) begin
            exp_word = exp_q.pop_front();
            chk("drain_dout", 64'(dout_a), 64'(exp_word));
            cyc_a(1'b0, 1'b1, 32'h0);
            chk("drain_count", 64'(count_a), 64'(3 - i));
        end
        chk("drain_empty", 64'(empty_a), 64'd1);
        chk("drain_dout0", 64'(dout_a),  64'd0);
        chk("drain_unf",   64'(unf_a),   64'd0);

        // Empty with write and read together: write lands, read refused
        cyc_a(1'b1, 1'b1, 32'h0000abcd);
        chk("wr_rd_empty_count", 64'(count_a), 64'd1);
        chk("wr_rd_empty_dout",  64'(dout_a),  64'h0000_0000_0000_abcd);
        chk("wr_rd_empty_unf",   64'(unf_a),   64'd1);

        // Fill to 3, then reset mid-operation while writing
        cyc_a(1'b1, 1'b0, 32'h11111111);
        cyc_a(1'b1, 1'b0, 32'h22222222);
        chk("pre_rst_count", 64'(count_a), 64'd3);
        reset = 1'b0; we_a = 1'b1; din_a = 32'h33333333;
        @(posedge clk); #1;
        reset = 1'b1; we_a = 1'b0; din_a = '0;
        chk("mid_rst_count", 64'(count_a), 64'd0);
        chk("mid_rst_empty", 64'(empty_a), 64'd1);
        chk("mid_rst_unf",   64'(unf_a),   64'd0);
        chk("mid_rst_ovf",   64'(ovf_a),   64'd0);
        chk("mid_rst_dout",  64'(dout_a),  64'd0);

        // Flush with a write: write ignored
        flush_cyc_a(1'b1, 32'h44444444);
        chk("flush_wr_count", 64'(count_a), 64'd0);
        chk("flush_wr_empty", 64'(empty_a), 64'd1);
        chk("flush_wr_dout",  64'(dout_a),  64'd0);

        // Flush during normal contents discards them
        cyc_a(1'b1, 1'b0, 32'h55555555);
        cyc_a(1'b1, 1'b0, 32'h66666666);
        flush_cyc_a(1'b0, 32'h0);
        chk("flush_data_count", 64'(count_a), 64'd0);
        chk("flush_data_dout",  64'(dout_a),  64'd0);

        // ---------------- instance b: depth 5, ordered 1..12 across wrap ----------------
        exp_q.delete();
        exp_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(32'(k));
            cyc_b(1'b1, 1'b0, 32'(k));
            exp_cnt++;
            chk("b_fill_count", 64'(count_b), 64'(exp_cnt));
            chk("b_fill_ae",    64'(ae_b),    64'(exp_cnt <= 2));
            chk("b_fill_af",    64'(af_b),    64'(exp_cnt >= 4));
            chk("b_fill_full",  64'(full_b),  64'(exp_cnt == 5));
            chk("b_fill_dout",  64'(dout_b),  64'd1);
        end
        for (int k = 6; k <= 12; k++) begin
            exp_word = exp_q.pop_front();
            chk("b_stream_dout", 64'(dout_b), 64'(exp_word));
            exp_q.push_back(32'(k));
            cyc_b(1'b1, 1'b1, 32'(k));
            chk("b_stream_count", 64'(count_b), 64'd5);
            chk("b_stream_full",  64'(full_b),  64'd1);
        end
        while (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            chk("b_drain_dout", 64'(dout_b), 64'(exp_word));
            cyc_b(1'b0, 1'b1, 32'h0);
            exp_cnt--;
            chk("b_drain_count", 64'(count_b), 64'(exp_cnt));
            chk("b_drain_ae",    64'(ae_b),    64'(exp_cnt <= 2));
        end
        chk("b_end_empty", 64'(empty_b), 64'd1);
        chk("b_end_ovf",   64'(ovf_b),   64'd0);
        chk("b_end_unf",   64'(unf_b),   64'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
